// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with KMP-style transitions built at elaboration.
// Optional saturating match counter compiled in with MOORE_SEQ_DETECTOR_COUNT_EN.
module moore_seq_detector #(
  parameter int          SEQ_LEN = 9,
  parameter logic [31:0] SEQ     = 32'b001011110,
  parameter bit          OVERLAP = 1'b1,
  parameter int          COUNT_W = 8
) (
  input  logic               clk,
  input  logic               state_reset_n,
  input  logic               r,
  input  logic               en,
  output logic               out,
  output logic [COUNT_W-1:0] match_count
);

  localparam int             SW   = $clog2(SEQ_LEN + 1);
  localparam logic [SW-1:0]  FULL = SW'(SEQ_LEN);

  // Pattern bit i counted from the first bit received.
  function automatic bit pat(input int i);
    return SEQ[SEQ_LEN-1-i];
  endfunction

  // Longest prefix of SEQ that is a suffix of (prefix[0..s-1], b).
  function automatic int kmp_from(input int s, input bit b);
    int res;
    bit ok;
    bit tb;
    res = 0;
    for (int k = 1; k <= s + 1; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        tb = (s + 1 - k + j == s) ? b : pat(s + 1 - k + j);
        if (pat(j) != tb) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  // Longest proper prefix of SEQ that is also a suffix of SEQ.
  function automatic int lps();
    int res;
    bit ok;
    res = 0;
    for (int k = 1; k < SEQ_LEN; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (pat(j) != pat(SEQ_LEN - k + j)) ok = 1'b0;
      if (ok) res = k;
    end
    return res;
  endfunction

  function automatic int next_state(input int s, input bit b);
    if (s >= SEQ_LEN) return kmp_from(OVERLAP ? lps() : 0, b);
    return kmp_from(s, b);
  endfunction

  logic [SEQ_LEN:0][SW-1:0] tbl0, tbl1;

  for (genvar g = 0; g <= SEQ_LEN; g++) begin : g_tbl
    localparam int N0 = next_state(g, 1'b0);
    localparam int N1 = next_state(g, 1'b1);
    assign tbl0[g] = N0[SW-1:0];
    assign tbl1[g] = N1[SW-1:0];
  end

  logic [SW-1:0] s_q, s_d;

  always_comb begin
    s_d = s_q;
    if (int'(s_q) > SEQ_LEN) s_d = '0;
    else if (en)             s_d = r ? tbl1[s_q] : tbl0[s_q];
  end

  always_ff @(posedge clk or negedge state_reset_n) begin
    if (!state_reset_n) s_q <= '0;
    else                s_q <= s_d;
  end

  assign out = (s_q == FULL);

`ifdef MOORE_SEQ_DETECTOR_COUNT_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (s_d == FULL) && (cnt_q != '1)) cnt_d = cnt_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge state_reset_n) begin
    if (!state_reset_n) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench: five detector configurations share r/en/reset; directed
// vectors push hand-computed expectations, a monitor pops and compares.
module tb_moore_seq_detector;

  logic clk = 1'b0;
  logic state_reset_n = 1'b0;
  logic r = 1'b0;
  logic en = 1'b0;

  logic       o0, o1, o2, o3, o4;
  logic [7:0] c0, c1, c3, c4;
  logic [3:0] c2;

  always #5 clk = ~clk;

  // 0: default overlap, 1: default non-overlap, 2: COUNT_W=4, 3/4: 1111 overlap/non-overlap
  moore_seq_detector u_a (.clk(clk), .state_reset_n(state_reset_n), .r(r), .en(en), .out(o0), .match_count(c0));
  moore_seq_detector #(.OVERLAP(1'b0)) u_b (.clk(clk), .state_reset_n(state_reset_n), .r(r), .en(en), .out(o1), .match_count(c1));
  moore_seq_detector #(.COUNT_W(4)) u_c (.clk(clk), .state_reset_n(state_reset_n), .r(r), .en(en), .out(o2), .match_count(c2));
  moore_seq_detector #(.SEQ_LEN(4), .SEQ(32'b1111), .OVERLAP(1'b1)) u_d (.clk(clk), .state_reset_n(state_reset_n), .r(r), .en(en), .out(o3), .match_count(c3));
  moore_seq_detector #(.SEQ_LEN(4), .SEQ(32'b1111), .OVERLAP(1'b0)) u_e (.clk(clk), .state_reset_n(state_reset_n), .r(r), .en(en), .out(o4), .match_count(c4));

  typedef struct {int d; bit o; int c;} ent_t;
  ent_t sb[$];
  int   exp_c [5];
  int   cap   [5] = '{255, 255, 15, 255, 255};
  int   n_tot = 0;
  int   n_pass = 0;
  event chk_ev;

  function automatic bit get_out(input int d);
    case (d)
      0: return o0;
      1: return o1;
      2: return o2;
      3: return o3;
      default: return o4;
    endcase
  endfunction

  function automatic int get_cnt(input int d);
    case (d)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      3: return int'(c3);
      default: return int'(c4);
    endcase
  endfunction

  function automatic int cnt_exp(input int v);
`ifdef MOORE_SEQ_DETECTOR_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic push(input int d, input bit o, input bit eb);
    if (o && eb && exp_c[d] < cap[d]) exp_c[d]++;
    sb.push_back('{d: d, o: o, c: cnt_exp(exp_c[d])});
  endtask

  // One enabled/disabled edge; m selects which DUTs get checked, o their expected out.
  task automatic vec(input bit rb, input bit eb, input logic [4:0] m, input logic [4:0] o);
    @(negedge clk);
    r  = rb;
    en = eb;
    @(posedge clk);
    for (int d = 0; d < 5; d++)
      if (m[d]) push(d, o[d], eb);
  endtask

  // Mid-cycle async assert, then an edge with reset held and r=en=1.
  task automatic do_reset();
    @(negedge clk);
    #1;
    state_reset_n = 1'b0;
    r  = 1'b1;
    en = 1'b1;
    for (int d = 0; d < 5; d++) exp_c[d] = 0;
    #1;
    for (int d = 0; d < 5; d++) push(d, 1'b0, 1'b0);
    ->chk_ev;
    @(posedge clk);
    for (int d = 0; d < 5; d++) push(d, 1'b0, 1'b0);
    @(negedge clk);
    state_reset_n = 1'b1;
    en = 1'b0;
  endtask

  initial begin : monitor
    ent_t e;
    int   n;
    n = 0;
    forever begin
      @(posedge clk or chk_ev);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n++;
        n_tot++;
        if (get_out(e.d) === e.o) n_pass++;
        else $display("FAIL out_dut%0d #%0d: got %b want %b", e.d, n, get_out(e.d), e.o);
        n_tot++;
        if (get_cnt(e.d) == e.c) n_pass++;
        else $display("FAIL cnt_dut%0d #%0d: got %0d want %0d", e.d, n, get_cnt(e.d), e.c);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin : stim
    logic [16:0] p1, ea, eb;
    logic [8:0]  pv;
    int          len;
    bit          last;

    for (int d = 0; d < 5; d++) exp_c[d] = 0;
    do_reset();

    // Single match then an overlapping second match (17 bits).
    p1 = 17'b001011110_01011110;
    ea = 17'b000000001_00000001;
    eb = 17'b000000001_00000000;
    for (int i = 0; i < 17; i++)
      vec(p1[16-i], 1'b1, 5'b00111, {2'b00, ea[16-i], eb[16-i], ea[16-i]});

    // en=0 gaps hold partial and full matches.
    do_reset();
    vec(1'b0, 1'b1, 5'b00011, 5'b00000);
    vec(1'b0, 1'b1, 5'b00011, 5'b00000);
    vec(1'b1, 1'b1, 5'b00011, 5'b00000);
    vec(1'b0, 1'b1, 5'b00011, 5'b00000);
    for (int i = 0; i < 5; i++) vec(1'($urandom_range(0, 1)), 1'b0, 5'b00011, 5'b00000);
    vec(1'b1, 1'b1, 5'b00011, 5'b00000);
    vec(1'b1, 1'b1, 5'b00011, 5'b00000);
    vec(1'b1, 1'b1, 5'b00011, 5'b00000);
    vec(1'b1, 1'b1, 5'b00011, 5'b00000);
    vec(1'b0, 1'b1, 5'b00011, 5'b00011);
    vec(1'($urandom_range(0, 1)), 1'b0, 5'b00011, 5'b00011);
    vec(1'($urandom_range(0, 1)), 1'b0, 5'b00011, 5'b00011);
    vec(1'b0, 1'b1, 5'b00011, 5'b00000);

    // Reset clears a live match and discards a partial one.
    do_reset();
    pv = 9'b001011110;
    for (int i = 0; i < 9; i++) vec(pv[8-i], 1'b1, 5'b00011, {4'b0000, i == 8, i == 8} >> 0 & 5'b00011 | {3'b000, (i == 8), (i == 8)});
    do_reset();
    pv = 9'b001011000;
    for (int i = 0; i < 6; i++) vec(pv[8-i], 1'b1, 5'b00011, 5'b00000);
    do_reset();
    vec(1'b1, 1'b1, 5'b00011, 5'b00000);
    vec(1'b1, 1'b1, 5'b00011, 5'b00000);
    vec(1'b0, 1'b1, 5'b00011, 5'b00000);

    // 20 back-to-back overlapping matches: 4-bit counter saturates at 15.
    do_reset();
    for (int m = 0; m < 20; m++) begin
      pv  = (m == 0) ? 9'b001011110 : 9'b001011110 & 9'b011111111;
      len = (m == 0) ? 9 : 8;
      for (int i = 0; i < len; i++) begin
        last = (i == len - 1);
        vec(pv[len-1-i], 1'b1, 5'b00101, {2'b00, last, 1'b0, last});
      end
    end

    // Seven 1s against 1111, overlapping vs non-overlapping.
    do_reset();
    for (int i = 1; i <= 7; i++)
      vec(1'b1, 1'b1, 5'b11000, {(i == 4), (i >= 4), 3'b000});

    @(posedge clk);
    #5;
    n_tot++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
MOORE_SEQ_DETECTOR -- requirements
Module: moore_seq_detector

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 9, meaning pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter SEQ, default 9'b001011110, meaning the target pattern; SEQ[SEQ_LEN-1] is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches, 0 = non-overlapping.
REQ-004 SHALL have parameter COUNT_W, default 8, meaning match-counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-006 SHALL have port state_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port r, input, 1 bit: serial data bit, sampled on the clk rising edge when en=1.
REQ-008 SHALL have port en, input, 1 bit: sample enable.
REQ-009 SHALL have port out, output, 1 bit: Moore match flag.
REQ-010 SHALL have port match_count, output, COUNT_W bits: saturating count of matches.

Function
REQ-011 SHALL hold a state register S in 0..SEQ_LEN, where S = number of pattern bits currently matched, encoded in clog2(SEQ_LEN+1) bits.
REQ-012 SHALL compute the next state from S<SEQ_LEN as the longest prefix of SEQ that is a suffix of (matched prefix followed by r), i.e. KMP failure transitions computed from the parameters at elaboration, with no runtime tables.
REQ-013 SHALL, from S=SEQ_LEN with OVERLAP=1, transition as from the longest proper prefix of SEQ that is also a suffix of SEQ.
REQ-014 SHALL, from S=SEQ_LEN with OVERLAP=0, transition exactly as from S=0.
REQ-015 SHALL make out a pure function of S: out=1 iff S==SEQ_LEN; out does not depend on r or en combinationally.
REQ-016 SHALL assert out for the whole cycle following the rising edge that sampled the final pattern bit (latency 1 edge), and for exactly one cycle unless en=0 holds it.
REQ-017 SHALL, when en=0 at an edge, leave S and match_count unchanged; out therefore holds its value.
REQ-018 SHALL leave the next-state decode free of latches; any unreachable S encoding transitions to 0.
REQ-019 SHALL increment match_count on every edge where the next state is SEQ_LEN and en=1.
REQ-020 SHALL saturate match_count at 2^COUNT_W-1 with no wrap-around.

Reset
REQ-021 SHALL, while state_reset_n=0, force S=0, out=0 and match_count=0 immediately, independent of clk.
REQ-022 SHALL discard any partial match in progress when reset asserts; detection restarts from S=0 on the first enabled edge after deassertion.
REQ-023 SHALL give reset priority over en and r at any coincident edge.

Configuration
REQ-024 SHALL compile the match counter only when macro MOORE_SEQ_DETECTOR_COUNT_EN is defined; with the macro defined, REQ-019/020 apply.
REQ-025 SHALL, without MOORE_SEQ_DETECTOR_COUNT_EN, keep the match_count port, tie it to constant 0, and instantiate no counter flops; S and out are unaffected.

Verification
REQ-026 Defaults, reset released, en=1, r stream 0,0,1,0,1,1,1,1,0 -> out=0 through edge 8; out=1 for one cycle after edge 9; match_count=1 (COUNT_EN defined).
REQ-027 OVERLAP=1, stream 001011110 then 01011110 (17 bits) -> out pulses after edges 9 and 17; match_count=2. Same stream with OVERLAP=0 -> single pulse after edge 9; match_count=1.
REQ-028 Stream 0010 followed by en=0 for 5 cycles with random r, then 11110 with en=1 -> single out pulse after the final enabled edge; S held during the en=0 cycles.
REQ-029 Stream 001011 followed by state_reset_n low mid-cycle, released, then 110 -> no pulse; out=0 and match_count=0 asynchronously during reset.
REQ-030 COUNT_W=4, 20 back-to-back matches -> match_count reaches 15 and remains 15; without MOORE_SEQ_DETECTOR_COUNT_EN, match_count=0 throughout and out pulses unchanged.
REQ-031 SEQ_LEN=4, SEQ=4'b1111, OVERLAP=1, seven 1s -> out high after edges 4,5,6,7; OVERLAP=0 -> out high after edge 4 only.
